// File: rtl/accum_col_ctrl_pkg.sv
// Shared definitions for the accumulator column controller: FSM encoding
// and the width/length derivations used by the top level.
package accum_col_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_MAX_OUT_ROWS = 128;
    localparam int DEF_MAX_OUT_COLS = 128;
    localparam int DEF_SYS_ARR_COLS = 16;
    localparam int DEF_PASS_W       = 8;

    // Accumulator rows needed to hold the widest tile split over the array columns.
    function automatic int calc_addr_w(input int rows, input int cols, input int arr_cols);
        return $clog2(rows * (cols / arr_cols));
    endfunction

    // Row counters must be able to hold the value MAX_OUT_ROWS itself.
    function automatic int calc_row_w(input int rows);
        return $clog2(rows) + 1;
    endfunction

    // Last skewed write lands arr_cols-1 cycles after column 0; one more for the RMW.
    function automatic int calc_flush_len(input int arr_cols);
        return arr_cols + 1;
    endfunction

endpackage

// File: rtl/accum_skew_line.sv
// Shift register that delays the column-0 write triple by 0..DEPTH-1 extra
// cycles; tap c feeds accumulator column c. Clear flushes every stage.
module accum_skew_line #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [DEPTH*WIDTH-1:0] taps
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_r;

    // Shift the write triple one column further each cycle; clear drops everything in flight.
    always_ff @(posedge clock) begin
        if (clear) begin
            stage_r <= {(DEPTH*WIDTH){1'b0}};
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign taps = stage_r;

endmodule

// File: rtl/accum_col_ctrl.sv
// Accumulator column sequencer: skewed per-column writes over num_passes
// K-passes (overwrite on pass 0, accumulate afterwards), then a row-by-row
// drain through a one-entry valid/ready output pipe.
module accum_col_ctrl
    import accum_col_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
    parameter int MAX_OUT_COLS = DEF_MAX_OUT_COLS,
    parameter int SYS_ARR_COLS = DEF_SYS_ARR_COLS,
    parameter int PASS_W       = DEF_PASS_W,
    parameter int ADDR_W       = calc_addr_w(MAX_OUT_ROWS, MAX_OUT_COLS, SYS_ARR_COLS),
    parameter int ROW_W        = calc_row_w(MAX_OUT_ROWS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ROW_W-1:0]               num_rows,
    input  logic [PASS_W-1:0]              num_passes,
    input  logic [ADDR_W-1:0]              tile_base,
    output logic                           busy,
    output logic                           done,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [SYS_ARR_COLS-1:0]        wr_en,
    output logic [SYS_ARR_COLS*ADDR_W-1:0] wr_addr,
    output logic [SYS_ARR_COLS-1:0]        acc_mode,
    output logic                           rd_en,
    output logic [ADDR_W-1:0]              rd_addr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ROW_W-1:0]               out_row
);

    localparam int FLUSH_LEN = calc_flush_len(SYS_ARR_COLS);
    localparam int FL_W      = $clog2(FLUSH_LEN + 1);
    localparam int SKEW_W    = ADDR_W + 2;

    // Data entries pass straight through the columns; only a sane width is required here.
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("accum_col_ctrl: DATA_WIDTH must be positive");
    end

    state_t                         state_r, state_next;
    logic [ROW_W-1:0]               num_rows_r, row_r, drow_r, out_row_r;
    logic [PASS_W-1:0]              num_passes_r, pass_r;
    logic [ADDR_W-1:0]              tile_base_r, rd_addr_r;
    logic [FL_W-1:0]                flush_cnt_r;
    logic                           busy_r, done_r, in_ready_r, out_valid_r;
    logic                           busy_next, done_next, in_ready_next;
    logic                           beat_s, last_row_s, last_pass_s, zero_job_s;
    logic                           rows_left_s, issue_s, final_hs_s;
    logic [SKEW_W-1:0]              skew_in_s;
    logic [SYS_ARR_COLS*SKEW_W-1:0] taps_s;

    assign beat_s      = (state_r == ST_ACCUM) & in_valid & in_ready_r;
    assign last_row_s  = (row_r == (num_rows_r - ROW_W'(1)));
    assign last_pass_s = (pass_r == (num_passes_r - PASS_W'(1)));
    assign zero_job_s  = (num_rows == {ROW_W{1'b0}}) | (num_passes == {PASS_W{1'b0}});
    assign rows_left_s = (drow_r != num_rows_r);
    // A new read may replace the held row only once it has been taken (or none is held).
    assign issue_s     = (state_r == ST_DRAIN) & rows_left_s & (~out_valid_r | out_ready);
    assign final_hs_s  = (state_r == ST_DRAIN) & ~rows_left_s & out_valid_r & out_ready;

    // Idle slots shift zeros so unused columns show no stray address or mode.
    assign skew_in_s = {beat_s,
                        beat_s & (pass_r != {PASS_W{1'b0}}),
                        beat_s ? (tile_base_r + ADDR_W'(row_r)) : {ADDR_W{1'b0}}};

    accum_skew_line #(
        .DEPTH (SYS_ARR_COLS),
        .WIDTH (SKEW_W)
    ) u_skew (
        .clock (clock),
        .clear (reset),
        .din   (skew_in_s),
        .taps  (taps_s)
    );

    for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_col
        assign wr_en[c]                    = taps_s[c*SKEW_W + ADDR_W + 1];
        assign acc_mode[c]                 = taps_s[c*SKEW_W + ADDR_W];
        assign wr_addr[c*ADDR_W +: ADDR_W] = taps_s[c*SKEW_W +: ADDR_W];
    end

    // Next-state and registered-flag decode; the pass-boundary bubble drops in_ready for one cycle.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (zero_job_s) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ACCUM;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (beat_s & last_row_s & last_pass_s) begin
                    state_next = ST_FLUSH;
                end else begin
                    state_next = ST_ACCUM;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == FL_W'(FLUSH_LEN - 1)) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (final_hs_s) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next     = (state_next == ST_ACCUM) | (state_next == ST_FLUSH) | (state_next == ST_DRAIN);
        done_next     = (state_next == ST_DONE);
        in_ready_next = (state_next == ST_ACCUM) & ~(beat_s & last_row_s);
    end

    // State register and registered control outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r    <= state_next;
            busy_r     <= busy_next;
            done_r     <= done_next;
            in_ready_r <= in_ready_next;
            if (issue_s) begin
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    // Job latch plus row/pass, flush and drain counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            num_rows_r   <= {ROW_W{1'b0}};
            num_passes_r <= {PASS_W{1'b0}};
            tile_base_r  <= {ADDR_W{1'b0}};
            row_r        <= {ROW_W{1'b0}};
            pass_r       <= {PASS_W{1'b0}};
            drow_r       <= {ROW_W{1'b0}};
            out_row_r    <= {ROW_W{1'b0}};
            rd_addr_r    <= {ADDR_W{1'b0}};
            flush_cnt_r  <= {FL_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        num_rows_r   <= num_rows;
                        num_passes_r <= num_passes;
                        tile_base_r  <= tile_base;
                        row_r        <= {ROW_W{1'b0}};
                        pass_r       <= {PASS_W{1'b0}};
                        drow_r       <= {ROW_W{1'b0}};
                    end
                end
                ST_ACCUM: begin
                    flush_cnt_r <= {FL_W{1'b0}};
                    if (beat_s) begin
                        if (last_row_s) begin
                            row_r  <= {ROW_W{1'b0}};
                            pass_r <= pass_r + PASS_W'(1);
                        end else begin
                            row_r <= row_r + ROW_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_cnt_r <= flush_cnt_r + FL_W'(1);
                    rd_addr_r   <= tile_base_r;
                    drow_r      <= {ROW_W{1'b0}};
                end
                ST_DRAIN: begin
                    if (issue_s) begin
                        drow_r    <= drow_r + ROW_W'(1);
                        rd_addr_r <= rd_addr_r + ADDR_W'(1);
                        out_row_r <= drow_r;
                    end
                end
                default: begin
                    flush_cnt_r <= {FL_W{1'b0}};
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign in_ready  = in_ready_r;
    assign rd_en     = issue_s;
    assign rd_addr   = rd_addr_r;
    assign out_valid = out_valid_r;
    assign out_row   = out_row_r;

endmodule

// File: tb/tb_accum_col_ctrl.sv
// Scoreboard bench for accum_col_ctrl: directed tiles push expected writes,
// reads and drained rows; a negedge monitor pops and compares.
module tb_accum_col_ctrl;

    localparam int AW   = 10;
    localparam int RW   = 8;
    localparam int PW   = 8;
    localparam int COLS = 16;

    logic               clock, reset, start;
    logic [RW-1:0]      num_rows;
    logic [PW-1:0]      num_passes;
    logic [AW-1:0]      tile_base;
    logic               busy, done, in_valid, in_ready;
    logic [COLS-1:0]    wr_en, acc_mode;
    logic [COLS*AW-1:0] wr_addr;
    logic               rd_en, out_valid, out_ready;
    logic [AW-1:0]      rd_addr;
    logic [RW-1:0]      out_row;

    accum_col_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .num_rows(num_rows),
        .num_passes(num_passes), .tile_base(tile_base), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .acc_mode(acc_mode), .rd_en(rd_en), .rd_addr(rd_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row)
    );

    int n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0, exp_done = 0;
    bit iv_en = 0, tog_mode = 0;
    logic [3:0] pat = 4'b1001;          // out_ready per cycle%4: 1,0,0,1

    logic [AW:0]   wr_q [COLS][$];      // {acc_mode, addr} per column
    int            exp_cyc [COLS][$];   // cycle each column write is due
    logic [AW-1:0] rd_q [$];
    int            out_q [$];
    int            beat_cyc [$];
    int            mem [COLS][1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Input driver: in_valid / out_ready, optionally with stall patterns.
    initial forever begin
        @(posedge clock);
        #1;
        in_valid  = iv_en && (!tog_mode || (cyc % 3 != 0));
        out_ready = !tog_mode || pat[cyc % 4];
    end

    // Monitor: compares every DUT event against the scoreboard.
    initial begin
        bit prev_rd, prev_stall;
        logic [RW-1:0] stall_row;
        logic [AW:0] e;
        logic [AW-1:0] a;
        prev_rd = 0; prev_stall = 0; stall_row = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_rd = 0;
                prev_stall = 0;
            end else begin
                if (prev_rd) chk("out_valid_after_rd", out_valid, 1);
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_row", out_row, stall_row);
                end
                if (in_valid && in_ready) begin
                    beat_cyc.push_back(cyc);
                    for (int c = 0; c < COLS; c++) exp_cyc[c].push_back(cyc + 1 + c);
                end
                for (int c = 0; c < COLS; c++) begin
                    if (wr_en[c]) begin
                        a = wr_addr[c*AW +: AW];
                        if (wr_q[c].size() == 0) unexpected("wr_en");
                        else begin
                            e = wr_q[c].pop_front();
                            chk("wr_addr", a, e[AW-1:0]);
                            chk("acc_mode", acc_mode[c], e[AW]);
                        end
                        if (exp_cyc[c].size() == 0) unexpected("wr_skew");
                        else chk("wr_skew_cycle", cyc, exp_cyc[c].pop_front());
                        mem[c][a] = acc_mode[c] ? mem[c][a] + 5 : 5;
                    end
                end
                if (rd_en) begin
                    if (rd_q.size() == 0) unexpected("rd_en");
                    else chk("rd_addr", rd_addr, rd_q.pop_front());
                end
                if (out_valid && out_ready) begin
                    if (out_q.size() == 0) unexpected("out_valid");
                    else chk("out_row", out_row, out_q.pop_front());
                end
                if (done) done_cnt++;
                prev_rd = rd_en;
                prev_stall = out_valid && !out_ready;
                stall_row = out_row;
            end
        end
    end

    task automatic clear_sb();
        for (int c = 0; c < COLS; c++) begin
            wr_q[c].delete();
            exp_cyc[c].delete();
        end
        rd_q.delete();
        out_q.delete();
        beat_cyc.delete();
    endtask

    task automatic push_tile(input int base, input int rows, input int passes);
        logic [AW:0] e;
        for (int p = 0; p < passes; p++)
            for (int r = 0; r < rows; r++) begin
                e = {p != 0, AW'((base + r) % 1024)};
                for (int c = 0; c < COLS; c++) wr_q[c].push_back(e);
            end
        for (int r = 0; r < rows; r++) begin
            rd_q.push_back(AW'((base + r) % 1024));
            out_q.push_back(r);
        end
    endtask

    task automatic pulse_start(input int base, input int rows, input int passes);
        @(posedge clock); #1;
        num_rows = RW'(rows); num_passes = PW'(passes); tile_base = AW'(base);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic run_tile(input int base, input int rows, input int passes, input bit tog);
        bit seen;
        int sz;
        beat_cyc.delete();
        push_tile(base, rows, passes);
        tog_mode = tog;
        iv_en = 1;
        pulse_start(base, rows, passes);
        chk("busy_after_start", busy, 1);
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clock);
            if (done) begin
                seen = 1;
                chk("busy_at_done", busy, 0);
            end
        end
        chk("done_seen", seen, 1);
        iv_en = 0;
        tog_mode = 0;
        exp_done++;
        @(posedge clock); #1;
        sz = rd_q.size() + out_q.size();
        for (int c = 0; c < COLS; c++) sz += wr_q[c].size() + exp_cyc[c].size();
        chk("scoreboard_drained", sz, 0);
        chk("done_count", done_cnt, exp_done);
    endtask

    task automatic check_gaps(input string name, input int exp_gaps[$]);
        chk(name, beat_cyc.size(), exp_gaps.size() + 1);
        for (int i = 1; i < beat_cyc.size() && i <= exp_gaps.size(); i++)
            chk(name, beat_cyc[i] - beat_cyc[i-1], exp_gaps[i-1]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_rows = '0; num_passes = '0; tile_base = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_acc_mode", acc_mode, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_row", out_row, 0);

        // 1: single pass, 4 rows from base 0
        run_tile(0, 4, 1, 0);
        check_gaps("t1_gap", '{1, 1, 1});

        // 2: 3 rows x 3 passes, bubble after beats 3 and 6
        run_tile(100, 3, 3, 0);
        check_gaps("t2_gap", '{1, 1, 2, 1, 1, 2, 1, 1});

        // 3: single row, 4 passes: never adjacent beats, accumulates 4x5
        run_tile(7, 1, 4, 0);
        check_gaps("t3_gap", '{2, 2, 2});
        chk("t3_accum_col0", mem[0][7], 20);
        chk("t3_accum_col15", mem[15][7], 20);

        // 4: address wrap 1022,1023,0,1 over two passes
        run_tile(1022, 4, 2, 0);
        chk("t4_accum_wrap", mem[3][0], 10);

        // 5: input and output stalls
        run_tile(50, 4, 1, 1);

        // 6: reset mid-ACCUM with every skew stage occupied
        push_tile(200, 40, 1);
        iv_en = 1;
        pulse_start(200, 40, 1);
        repeat (20) @(posedge clock);
        #1;
        chk("t6_skew_full", wr_en, 16'hFFFF);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("t6_rst_wr_en", wr_en, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        clear_sb();
        reset = 1'b0;
        iv_en = 0;

        // zero-row job: done next cycle, busy never rises; start held into DONE is ignored
        @(posedge clock); #1;
        num_rows = '0; num_passes = 8'd3; tile_base = 10'd5; start = 1'b1;
        @(posedge clock); #1;
        chk("t6_zero_done", done, 1);
        chk("t6_zero_busy", busy, 0);
        @(posedge clock); #1;
        start = 1'b0;
        chk("t6_start_in_done_ignored", done, 0);
        exp_done++;
        // zero-pass job
        pulse_start(9, 5, 0);
        chk("t6_zero_pass_done", done, 1);
        chk("t6_zero_pass_busy", busy, 0);
        exp_done++;
        repeat (20) @(posedge clock);
        #1;
        chk("t6_done_count", done_cnt, exp_done);

        // recovery after reset
        run_tile(3, 2, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
